// File: rtl/alu_mul_sequencer.sv
// LEGv8 MUL sequencer: computes the low WIDTH bits of a WIDTH x WIDTH product
// by shift-and-add, borrowing the EX-stage ALU for one add per iteration and
// stalling the pipeline until the product is ready.
module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] ex_A,
  input  logic [WIDTH-1:0] ex_B,
  input  logic [2:0]       ex_cntrl,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [2:0] ALU_ADD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  // Stop once every remaining multiplier bit is zero or all WIDTH bits are consumed;
  // this gives max(1, msb index + 1) RUN cycles.
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || ((q_reg >> 1) == '0);

  // Pipeline freezes for the whole multiply, including the cycle start is seen in IDLE.
  assign stall = busy || ((state == IDLE) && start);

  // ALU operand mux: sequencer owns the ALU only while in RUN.
  always_comb begin
    alu_A     = ex_A;
    alu_B     = ex_B;
    alu_cntrl = ex_cntrl;
    if (state == RUN) begin
      alu_A     = acc;
      alu_B     = q_reg[0] ? m_reg : '0;
      alu_cntrl = ALU_ADD;
    end
  end

  // Control FSM with shift-add datapath and registered busy/done/product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      m_reg   <= '0;
      q_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= mcand;
            q_reg <= mplier;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= alu_result;
          m_reg <= m_reg << 1;
          q_reg <= q_reg >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            product <= alu_result;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer: behavioural ALU plus a product scoreboard.
module tb_alu_mul_sequencer;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] ex_A;
  logic [WIDTH-1:0] ex_B;
  logic [2:0]       ex_cntrl;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [2:0]       alu_cntrl;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] product;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] sb[$];

  alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .ex_A(ex_A), .ex_B(ex_B), .ex_cntrl(ex_cntrl),
    .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl), .alu_result(alu_result),
    .busy(busy), .stall(stall), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural LEGv8 ALU.
  always_comb begin
    case (alu_cntrl)
      3'b000:  alu_result = alu_A & alu_B;
      3'b001:  alu_result = alu_A | alu_B;
      3'b010:  alu_result = alu_A + alu_B;
      3'b110:  alu_result = alu_A - alu_B;
      default: alu_result = '0;
    endcase
  end

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    ex_A = 64'd10; ex_B = 64'd4; ex_cntrl = 3'b011;
    repeat (2) @(negedge clk);
    checks++; if (alu_A !== 64'd10) begin errors++; $display("FAIL reset_alu_A: got %0h want a", alu_A); end
    checks++; if (alu_B !== 64'd4) begin errors++; $display("FAIL reset_alu_B: got %0h want 4", alu_B); end
    checks++; if (alu_cntrl !== 3'b011) begin errors++; $display("FAIL reset_alu_cntrl: got %b want 011", alu_cntrl); end
    checks++; if ({busy, stall, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, stall, done}); end
    checks++; if (product !== '0) begin errors++; $display("FAIL reset_product: got %0h want 0", product); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if ({busy, stall, done} !== 3'b000 || alu_cntrl !== 3'b011) begin
      errors++; $display("FAIL idle_after_reset: got flags %b cntrl %b want 000 011", {busy, stall, done}, alu_cntrl);
    end
  endtask

  // Runs one multiply; disturb pokes start during RUN and DONE.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int exp_runs, input bit disturb, input string name);
    int runs;
    int extra;
    bit seen;
    bit run_ok;
    logic [WIDTH-1:0] exp_p;
    sb.push_back(a * b);
    @(posedge clk); #1;
    start = 1'b1; mcand = a; mplier = b;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s_start_stall: got %b want 1", name, stall); end
    @(posedge clk); #1;
    start = 1'b0; mcand = 64'hDEAD_BEEF_0000_1234; mplier = 64'h5555;
    runs = 0; seen = 1'b0; run_ok = 1'b1;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) begin
        runs++;
        if (alu_cntrl !== 3'b010 || stall !== 1'b1) run_ok = 1'b0;
        if (runs == 1) begin
          checks++;
          if (alu_A !== '0 || alu_B !== (b[0] ? a : '0)) begin
            errors++; $display("FAIL %s_first_ops: got %0h %0h want 0 %0h", name, alu_A, alu_B, b[0] ? a : '0);
          end
        end
        if (disturb && runs == 10) begin start = 1'b1; mcand = 64'd11; mplier = 64'd13; end
        if (disturb && runs == 12) start = 1'b0;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL %s_done_timeout: got none want done pulse", name); end
    checks++; if (runs != exp_runs) begin errors++; $display("FAIL %s_run_cycles: got %0d want %0d", name, runs, exp_runs); end
    checks++; if (!run_ok) begin errors++; $display("FAIL %s_run_ctrl: got bad cntrl/stall want 010/1", name); end
    exp_p = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (product !== exp_p) begin errors++; $display("FAIL %s_product: got %0h want %0h", name, product, exp_p); end
    checks++; if (busy !== 1'b0 || stall !== 1'b0 || alu_A !== ex_A || alu_cntrl !== ex_cntrl) begin
      errors++; $display("FAIL %s_done_state: got busy %b stall %b A %0h cntrl %b want 0 0 a 011", name, busy, stall, alu_A, alu_cntrl);
    end
    if (disturb) begin
      start = 1'b1; mcand = 64'd2; mplier = 64'd2;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL %s_start_in_done: got busy %b done %b want 0 0", name, busy, done);
      end
      start = 1'b0;
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL %s_no_second_done: got %0d active cycles want 0", name, extra); end
    checks++; if (product !== exp_p) begin errors++; $display("FAIL %s_product_hold: got %0h want %0h", name, product, exp_p); end
  endtask

  task automatic test_abort();
    int runs;
    int dones;
    @(posedge clk); #1;
    start = 1'b1; mcand = 64'd9; mplier = 64'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    runs = 0;
    for (int i = 0; i < 20 && runs < 3; i++) begin
      @(negedge clk);
      if (busy === 1'b1) runs++;
    end
    checks++; if (runs != 3) begin errors++; $display("FAIL abort_reach_run: got %0d want 3", runs); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({busy, stall, done} !== 3'b000 || product !== '0) begin
      errors++; $display("FAIL abort_async_clear: got flags %b product %0h want 000 0", {busy, stall, done}, product);
    end
    checks++; if (alu_A !== ex_A || alu_B !== ex_B || alu_cntrl !== ex_cntrl) begin
      errors++; $display("FAIL abort_passthrough: got %0h %0h %b want a 4 011", alu_A, alu_B, alu_cntrl);
    end
    @(posedge clk); #1 reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++; if (dones != 0 || product !== '0) begin
      errors++; $display("FAIL abort_no_done: got %0d active product %0h want 0 0", dones, product);
    end
  endtask

  initial begin
    test_reset();
    run_mul(64'd7, 64'd3, 2, 1'b0, "mul_7x3");
    run_mul(64'd5, 64'd0, 1, 1'b0, "mul_by_zero");
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2, 1'b0, "mul_wrap");
    run_mul(64'd3, 64'h8000_0000_0000_0000, 64, 1'b1, "mul_long");
    run_mul(64'h0123_4567_89AB_CDEF, 64'h0000_0000_0001_0F0F, 17, 1'b0, "mul_mixed");
    test_abort();
    run_mul(64'd6, 64'd7, 3, 1'b0, "mul_after_abort");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle sequencer that runs LEGv8 MUL (low 64 bits of a 64x64 product) on the EX-stage 64-bit ALU.
- Uses shift-and-add over repeated ALU add operations.
- Arbitrates the ALU operand/control inputs between the normal EX datapath and itself.
- Stalls the pipeline while the multiply runs.

Parameters:
- WIDTH, 64, operand/result width; fixed to the ALU width.
- CNT_W, 7, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  MUL request from EX decode; sampled only in IDLE.
- mcand  input  WIDTH  multiplicand, captured on accepted start.
- mplier  input  WIDTH  multiplier, captured on accepted start.
- ex_A  input  WIDTH  normal EX ALU operand A.
- ex_B  input  WIDTH  normal EX ALU operand B.
- ex_cntrl  input  3  normal EX ALU control code.
- alu_A  output  WIDTH  to ALU A.
- alu_B  output  WIDTH  to ALU B.
- alu_cntrl  output  3  to ALU cntrl.
- alu_result  input  WIDTH  ALU result feedback.
- busy  output  1  high in RUN.
- stall  output  1  freezes IF/ID/EX pipeline registers.
- done  output  1  one-cycle pulse; product valid.
- product  output  WIDTH  low WIDTH bits of mcand*mplier; held until next accepted start.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high. While reset is high:
  - state=IDLE; M, Q, acc, cnt, product all 0.
  - busy=0, done=0.
  - ALU mux in passthrough.
- Reset asserted mid-operation aborts the multiply; no done pulse follows.
- States: IDLE, RUN, DONE (one-hot or binary, implementer's choice).
- IDLE:
  - alu_A=ex_A, alu_B=ex_B, alu_cntrl=ex_cntrl.
  - stall=start (combinational), so the MUL instruction holds in EX.
  - On clk with start=1: M<=mcand, Q<=mplier, acc<=0, cnt<=0; go RUN.
- RUN, each cycle:
  - alu_A=acc.
  - alu_B = Q[0] ? M : 0.
  - alu_cntrl=3'b010 (add).
  - busy=1, stall=1.
  - On clk: acc<=alu_result, M<=M<<1, Q<=Q>>1, cnt<=cnt+1.
- RUN exit: leave RUN for DONE on the edge where cnt==WIDTH-1 or (Q>>1)==0; product<=alu_result on that edge.
- Latency: number of RUN cycles = max(1, index of highest set bit of mplier + 1); range 1..64.
- DONE (exactly one cycle):
  - done=1, busy=0, stall=0.
  - ALU mux back to passthrough; the pipeline advances and captures product.
  - Next state IDLE unconditionally; start is ignored in DONE.
- start asserted in RUN or DONE is ignored; captured operands are not disturbed.
- mcand/mplier changing after acceptance has no effect.
- Arithmetic:
  - Unsigned shift-add, modulo 2^WIDTH. Bits shifted out of M are discarded.
  - The ALU overflow/carry_out flags are ignored.
  - The low half is identical for signed and unsigned operands, so no sign handling is needed.
- The sequencer never drives ALU control codes other than 010 or the ex_cntrl passthrough.
- Back-to-back MULs: minimum gap is one IDLE cycle after DONE before the next start is accepted.

Test Plan:
1. Reset, then IDLE with ex_A=10, ex_B=4, ex_cntrl=011 -> alu_A=10, alu_B=4, alu_cntrl=011; busy=0, stall=0, done=0, product=0.
2. start with mcand=7, mplier=3 -> stall=1 in the start cycle; RUN 2 cycles with alu_cntrl=010; done pulses on the 3rd edge-cycle after acceptance; product=21; product holds 21 afterwards.
3. start with mcand=5, mplier=0 -> 1 RUN cycle, done next cycle, product=0.
4. start with mcand=0xFFFF_FFFF_FFFF_FFFF, mplier=2 -> 2 RUN cycles, product=0xFFFF_FFFF_FFFF_FFFE (wraparound).
5. start with mcand=3, mplier=0x8000_0000_0000_0000 -> 64 RUN cycles, then product=0x8000_0000_0000_0000. Assert start with new operands during RUN -> ignored; result unchanged; no second done.
6. start with mcand=9, mplier=0xFF; assert reset after 3 RUN cycles -> busy/stall/done/product drop to 0 immediately (asynchronous); state IDLE; passthrough resumes; no done pulse after reset release.
